// File: rtl/disp_pkg.sv
// Shared constants and types for the display pixel path (VRAM read data -> panel RGB).
package disp_pkg;

   localparam int unsigned FIFO_ADDR_W   = 9;
   localparam int unsigned BURST_LEN_DEF = 8;

   localparam int unsigned R_MSB = 23;
   localparam int unsigned R_LSB = 16;
   localparam int unsigned G_MSB = 15;
   localparam int unsigned G_LSB = 8;
   localparam int unsigned B_MSB = 7;
   localparam int unsigned B_LSB = 0;
   localparam int unsigned PIX_W = 24;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   localparam pix_t PIX_BLACK = '0;

   function automatic pix_t rdata_to_pix(input logic [PIX_W-1:0] d);
      pix_t p;
      p.r = d[R_MSB:R_LSB];
      p.g = d[G_MSB:G_LSB];
      p.b = d[B_MSB:B_LSB];
      return p;
   endfunction

endpackage

// File: rtl/disp_pixbuf_gsync.sv
// Pointer crossing: registered bin->gray in the source clock, 2-flop sync and gray->bin in the
// destination clock.
module disp_pixbuf_gsync #(
   parameter int unsigned W = 10
) (
   input  logic         src_clk_i,
   input  logic         src_rst_i,
   input  logic [W-1:0] src_bin_i,
   input  logic         dst_clk_i,
   input  logic         dst_rst_i,
   output logic [W-1:0] dst_gray_o,
   output logic [W-1:0] dst_bin_o
);

   logic [W-1:0] src_gray_q;
   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;

   // Gray must leave the source domain from a flop so only one bit can change per edge.
   always_ff @(posedge src_clk_i) begin
      if (src_rst_i) begin
         src_gray_q <= '0;
      end else begin
         src_gray_q <= src_bin_i ^ (src_bin_i >> 1);
      end
   end

   always_ff @(posedge dst_clk_i) begin
      if (dst_rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_gray_q;
         sync2_q <= sync1_q;
      end
   end

   assign dst_gray_o = sync2_q;

   always_comb begin
      dst_bin_o = '0;
      for (int i = 0; i < int'(W); i++) begin
         dst_bin_o[i] = ^(sync2_q >> i);
      end
   end

endmodule

// File: rtl/disp_pixbuf.sv
// Dual-clock pixel FIFO: AXI R beats captured on ACLK, RGB/DE driven to the panel on DCLK.
// Optional sticky underflow reporting on BUF_UNDER: define DISP_PIXBUF_UNDERFLOW_EN.
module disp_pixbuf
   import disp_pkg::*;
#(
   parameter int unsigned ADDR_W    = FIFO_ADDR_W,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
   input  logic              ACLK,
   input  logic              ARST,
   input  logic              DCLK,
   input  logic [DATA_W-1:0] RDATA,
   input  logic              RVALID,
   input  logic              RREADY,
   input  logic              DISPON,
   output logic              BUF_WREADY,
   input  logic              DSP_preDE,
   output logic [7:0]        DSP_R,
   output logic [7:0]        DSP_G,
   output logic [7:0]        DSP_B,
   output logic              DSP_DE,
   output logic              BUF_UNDER
);

   localparam int unsigned PtrW  = ADDR_W + 1;
   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic [PtrW-1:0] LvlMax = PtrW'(Depth - BURST_LEN);

   pix_t mem [Depth];

   // ---------------- ACLK domain ----------------
   logic [PtrW-1:0] wptr_q, wptr_d, wgray;
   logic [PtrW-1:0] rptr_sync, rgray_sync;
   logic            full, push;
   logic            wready_q, wready_d;
   pix_t            pix_in;
   logic            unused_rdata;

   assign unused_rdata = ^RDATA[DATA_W-1:PIX_W];
   assign pix_in       = rdata_to_pix(RDATA[PIX_W-1:0]);

   assign wgray = wptr_q ^ (wptr_q >> 1);
   assign full  = (wgray == {~rgray_sync[PtrW-1:PtrW-2], rgray_sync[PtrW-3:0]});
   // AXI is never stalled: a beat arriving while full is simply lost.
   assign push  = RVALID & RREADY & DISPON & ~full;

   always_comb begin
      wptr_d   = push ? wptr_q + PtrW'(1) : wptr_q;
      wready_d = DISPON & ((wptr_q - rptr_sync) <= LvlMax);
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         wptr_q   <= '0;
         wready_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         wready_q <= wready_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push) begin
         mem[wptr_q[ADDR_W-1:0]] <= pix_in;
      end
   end

   assign BUF_WREADY = wready_q;

   // ---------------- DCLK domain ----------------
   logic [1:0]      drst_q;
   logic            drst;
   logic [1:0]      dispon_s_q;
   logic            dispon_dclk;
   logic [PtrW-1:0] rptr_q, rptr_d, rgray;
   logic [PtrW-1:0] wptr_sync, wgray_sync;
   logic            empty, pop;
   pix_t            pix_q;
   logic            de_q;

   always_ff @(posedge DCLK) begin
      drst_q <= {drst_q[0], ARST};
   end
   assign drst = drst_q[1];

   assign dispon_dclk = dispon_s_q[1];
   assign rgray       = rptr_q ^ (rptr_q >> 1);
   assign empty       = (rgray == wgray_sync);
   assign pop         = DSP_preDE & ~empty & dispon_dclk;

   // While the display is off the read side chases the writer, flushing whatever is queued.
   always_comb begin
      rptr_d = rptr_q;
      if (!dispon_dclk) begin
         rptr_d = wptr_sync;
      end else if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge DCLK) begin
      if (drst) begin
         dispon_s_q <= '0;
         rptr_q     <= '0;
         pix_q      <= PIX_BLACK;
         de_q       <= 1'b0;
      end else begin
         dispon_s_q <= {dispon_s_q[0], DISPON};
         rptr_q     <= rptr_d;
         pix_q      <= pop ? mem[rptr_q[ADDR_W-1:0]] : PIX_BLACK;
         de_q       <= DSP_preDE;
      end
   end

   assign DSP_R  = pix_q.r;
   assign DSP_G  = pix_q.g;
   assign DSP_B  = pix_q.b;
   assign DSP_DE = de_q;

   disp_pixbuf_gsync #(
      .W(PtrW)
   ) u_wptr_sync (
      .src_clk_i (ACLK),
      .src_rst_i (ARST),
      .src_bin_i (wptr_q),
      .dst_clk_i (DCLK),
      .dst_rst_i (drst),
      .dst_gray_o(wgray_sync),
      .dst_bin_o (wptr_sync)
   );

   disp_pixbuf_gsync #(
      .W(PtrW)
   ) u_rptr_sync (
      .src_clk_i (DCLK),
      .src_rst_i (drst),
      .src_bin_i (rptr_q),
      .dst_clk_i (ACLK),
      .dst_rst_i (ARST),
      .dst_gray_o(rgray_sync),
      .dst_bin_o (rptr_sync)
   );

   // ---------------- underflow reporting ----------------
`ifdef DISP_PIXBUF_UNDERFLOW_EN
   logic       und_flag_q;
   logic       und_tgl_q;
   logic [2:0] und_sync_q;
   logic [1:0] drst_ack_q;
   logic       dispon_q;
   logic       under_q;

   // One toggle per frame: the flag re-arms only once the display has been switched off.
   always_ff @(posedge DCLK) begin
      if (drst) begin
         und_flag_q <= 1'b0;
         und_tgl_q  <= 1'b0;
      end else if (!dispon_dclk) begin
         und_flag_q <= 1'b0;
      end else if (DSP_preDE && empty && !und_flag_q) begin
         und_flag_q <= 1'b1;
         und_tgl_q  <= ~und_tgl_q;
      end
   end

   // Toggles caused by DRST clearing und_tgl_q are masked via the echoed DRST.
   always_ff @(posedge ACLK) begin
      und_sync_q <= {und_sync_q[1:0], und_tgl_q};
      drst_ack_q <= {drst_ack_q[0], drst};
      if (ARST) begin
         dispon_q <= 1'b0;
         under_q  <= 1'b0;
      end else begin
         dispon_q <= DISPON;
         if (DISPON && !dispon_q) begin
            under_q <= 1'b0;
         end else if (!drst_ack_q[1] && (und_sync_q[2] ^ und_sync_q[1])) begin
            under_q <= 1'b1;
         end
      end
   end

   assign BUF_UNDER = under_q;
`else
   assign BUF_UNDER = 1'b0;
`endif

endmodule

// File: tb/tb_disp_pixbuf.sv
// Self-checking bench for disp_pixbuf: random pixel data against a queue model of the FIFO.
module tb_disp_pixbuf;

   localparam int unsigned Depth = 512;
`ifdef DISP_PIXBUF_UNDERFLOW_EN
   localparam logic UnderEn = 1'b1;
`else
   localparam logic UnderEn = 1'b0;
`endif

   logic        ACLK = 1'b0;
   logic        DCLK = 1'b0;
   logic        ARST = 1'b1;
   logic [31:0] RDATA = '0;
   logic        RVALID = 1'b0;
   logic        RREADY = 1'b0;
   logic        DISPON = 1'b1;
   logic        BUF_WREADY;
   logic        DSP_preDE = 1'b0;
   logic [7:0]  DSP_R, DSP_G, DSP_B;
   logic        DSP_DE;
   logic        BUF_UNDER;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] mq[$];

   disp_pixbuf dut (
      .ACLK      (ACLK),
      .ARST      (ARST),
      .DCLK      (DCLK),
      .RDATA     (RDATA),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .DISPON    (DISPON),
      .BUF_WREADY(BUF_WREADY),
      .DSP_preDE (DSP_preDE),
      .DSP_R     (DSP_R),
      .DSP_G     (DSP_G),
      .DSP_B     (DSP_B),
      .DSP_DE    (DSP_DE),
      .BUF_UNDER (BUF_UNDER)
   );

   // ACLK 100 MHz, DCLK 25 MHz, offset so edges never coincide.
   always #5 ACLK = ~ACLK;
   initial begin
      #3;
      forever #20 DCLK = ~DCLK;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // One ACLK beat; call at negedge ACLK, returns at the next negedge.
   task automatic beat(input logic v, input logic r, input logic [31:0] d);
      RVALID = v;
      RREADY = r;
      RDATA  = d;
      @(negedge ACLK);
      RVALID = 1'b0;
      RREADY = 1'b0;
      if (v && r && DISPON && mq.size() < Depth) mq.push_back(d[23:0]);
   endtask

   // One DCLK cycle; call at negedge DCLK, samples outputs at the next negedge.
   task automatic dstep(input logic de, output logic [23:0] px, output logic de_o);
      DSP_preDE = de;
      @(negedge DCLK);
      px        = {DSP_R, DSP_G, DSP_B};
      de_o      = DSP_DE;
      DSP_preDE = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge ACLK);
      repeat (5) @(negedge DCLK);
   endtask

   task automatic test_reset();
      ARST = 1'b1;
      DISPON = 1'b1;
      repeat (3) @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b0) begin
         errors++;
         $display("FAIL reset_wready: got %b required 0", BUF_WREADY);
      end
      repeat (12) @(negedge ACLK);
      @(negedge DCLK);
      checks++;
      if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== 26'h0) begin
         errors++;
         $display("FAIL reset_outputs: got de=%b rgb=%h under=%b required all 0",
                  DSP_DE, {DSP_R, DSP_G, DSP_B}, BUF_UNDER);
      end
      @(negedge ACLK);
      ARST = 1'b0;
      repeat (2) @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_wready: got %b required 1", BUF_WREADY);
      end
      repeat (4) @(negedge DCLK);
      mq.delete();
   endtask

   task automatic test_burst();
      logic [23:0] px, exp;
      logic        deo;
      @(negedge ACLK);
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(0, 2) == 0) beat(1'b1, 1'b0, $urandom);
         beat(1'b1, 1'b1, {8'($urandom), 24'hAABBCC + 24'(n)});
      end
      beat(1'b0, 1'b1, $urandom);
      settle();
      @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL burst_wready: got %b required 1", BUF_WREADY);
      end
      @(negedge DCLK);
      for (int n = 0; n < 8; n++) begin
         dstep(1'b1, px, deo);
         exp = (mq.size() > 0) ? mq.pop_front() : 24'h0;
         checks++;
         if ({deo, px} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL burst_pix%0d: got de=%b rgb=%h required de=1 rgb=%h", n, deo, px, exp);
         end
      end
      dstep(1'b0, px, deo);
      checks++;
      if ({deo, px} !== 25'h0) begin
         errors++;
         $display("FAIL burst_idle: got de=%b rgb=%h required de=0 rgb=000000", deo, px);
      end
   endtask

   task automatic test_fill();
      logic [23:0] px, exp;
      logic        deo;
      @(negedge ACLK);
      for (int i = 0; i < 504; i++) beat(1'b1, 1'b1, {8'h00, 24'($urandom)});
      @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL fill_wready_504: got %b required 1", BUF_WREADY);
      end
      beat(1'b1, 1'b1, {8'h00, 24'($urandom)});
      @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b0) begin
         errors++;
         $display("FAIL fill_wready_505: got %b required 0", BUF_WREADY);
      end
      for (int i = 0; i < 7; i++) beat(1'b1, 1'b1, {8'h00, 24'($urandom)});
      beat(1'b1, 1'b1, 32'h00DEAD01);
      checks++;
      if (mq.size() != Depth) begin
         errors++;
         $display("FAIL fill_model_size: got %0d required %0d", mq.size(), Depth);
      end
      settle();
      for (int i = 0; i < int'(Depth); i++) begin
         dstep(1'b1, px, deo);
         exp = (mq.size() > 0) ? mq.pop_front() : 24'h0;
         checks++;
         if ({deo, px} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL fill_pix%0d: got de=%b rgb=%h required de=1 rgb=%h", i, deo, px, exp);
         end
      end
      settle();
      @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL fill_drained_wready: got %b required 1", BUF_WREADY);
      end
   endtask

   task automatic test_underflow();
      logic [23:0] px;
      logic        deo;
      logic        seen;
      @(negedge DCLK);
      checks++;
      if (BUF_UNDER !== 1'b0) begin
         errors++;
         $display("FAIL under_before: got %b required 0", BUF_UNDER);
      end
      dstep(1'b1, px, deo);
      checks++;
      if ({deo, px} !== {1'b1, 24'h0}) begin
         errors++;
         $display("FAIL under_pix: got de=%b rgb=%h required de=1 rgb=000000", deo, px);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge ACLK);
         if (BUF_UNDER === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== UnderEn) begin
         errors++;
         $display("FAIL under_flag: got %b required %b", seen, UnderEn);
      end
      @(negedge DCLK);
      repeat (3) dstep(1'b0, px, deo);
      checks++;
      if ({BUF_UNDER, deo, px} !== {UnderEn, 25'h0}) begin
         errors++;
         $display("FAIL under_sticky: got under=%b de=%b rgb=%h required under=%b de=0 rgb=0",
                  BUF_UNDER, deo, px, UnderEn);
      end
   endtask

   task automatic test_flush();
      logic [23:0] px, exp;
      logic        deo;
      @(negedge ACLK);
      for (int i = 0; i < 100; i++) beat(1'b1, 1'b1, {8'h00, 24'($urandom) | 24'h1});
      settle();
      @(negedge ACLK);
      DISPON = 1'b0;
      mq.delete();
      repeat (2) @(negedge ACLK);
      checks++;
      if (BUF_WREADY !== 1'b0) begin
         errors++;
         $display("FAIL flush_wready_off: got %b required 0", BUF_WREADY);
      end
      beat(1'b1, 1'b1, 32'h00123456);
      @(negedge DCLK);
      repeat (4) @(negedge DCLK);
      dstep(1'b1, px, deo);
      checks++;
      if ({deo, px} !== {1'b1, 24'h0}) begin
         errors++;
         $display("FAIL flush_black: got de=%b rgb=%h required de=1 rgb=000000", deo, px);
      end
      checks++;
      if (BUF_UNDER !== UnderEn) begin
         errors++;
         $display("FAIL flush_under_held: got %b required %b", BUF_UNDER, UnderEn);
      end
      @(negedge ACLK);
      DISPON = 1'b1;
      repeat (3) @(negedge ACLK);
      checks++;
      if ({BUF_WREADY, BUF_UNDER} !== 2'b10) begin
         errors++;
         $display("FAIL flush_restart: got wready=%b under=%b required wready=1 under=0",
                  BUF_WREADY, BUF_UNDER);
      end
      repeat (4) @(negedge DCLK);
      @(negedge ACLK);
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, {8'h00, 24'($urandom) | 24'h1});
      settle();
      for (int i = 0; i < 3; i++) begin
         dstep(1'b1, px, deo);
         exp = (mq.size() > 0) ? mq.pop_front() : 24'h0;
         checks++;
         if ({deo, px} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL flush_newframe%0d: got de=%b rgb=%h required de=1 rgb=%h",
                     i, deo, px, exp);
         end
      end
   endtask

   // Scaled-down frame (32 lines of 64 pixels with blanking) at the 4:1 clock ratio.
   task automatic test_clock_ratio();
      localparam int N = 2048;
      int sent;
      int got;
      sent = 0;
      got  = 0;
      fork
         begin : writer
            int wc;
            wc = 0;
            @(negedge ACLK);
            while (sent < N && wc < 40000) begin
               if (BUF_WREADY) begin
                  for (int k = 0; k < 8; k++) beat(1'b1, 1'b1, {8'($urandom), 24'($urandom) | 24'h1});
                  sent += 8;
                  repeat (2) @(negedge ACLK);
                  wc += 10;
               end else begin
                  @(negedge ACLK);
                  wc++;
               end
            end
         end
         begin : reader
            logic [23:0] px, exp;
            logic        deo, de;
            int          waited;
            waited = 0;
            while (sent < 256 && waited < 2000) begin
               @(negedge ACLK);
               waited++;
            end
            @(negedge DCLK);
            for (int i = 0; i < 4000 && got < N; i++) begin
               de = ((i % 80) < 64);
               dstep(de, px, deo);
               if (de) begin
                  got++;
                  exp = (mq.size() > 0) ? mq.pop_front() : 24'h0;
                  checks++;
                  if ({deo, px} !== {1'b1, exp}) begin
                     errors++;
                     $display("FAIL ratio_pix%0d: got de=%b rgb=%h required de=1 rgb=%h",
                              got, deo, px, exp);
                  end
               end else begin
                  checks++;
                  if ({deo, px} !== 25'h0) begin
                     errors++;
                     $display("FAIL ratio_blank%0d: got de=%b rgb=%h required de=0 rgb=0",
                              i, deo, px);
                  end
               end
            end
         end
      join
      checks++;
      if (got != N || mq.size() != 0) begin
         errors++;
         $display("FAIL ratio_count: got %0d pixels (%0d left) required %0d (0 left)",
                  got, mq.size(), N);
      end
      repeat (4) @(negedge ACLK);
      checks++;
      if (BUF_UNDER !== 1'b0) begin
         errors++;
         $display("FAIL ratio_no_underflow: got %b required 0", BUF_UNDER);
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_fill();
      test_underflow();
      test_flush();
      test_clock_ratio();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
